// File: rtl/fb_write_scheduler.sv
// rtl/fb_write_scheduler.sv - frame buffer write-port scheduler: CPU pixel writes, clear fill, vblank-aligned swap
module fb_write_scheduler #(
   parameter int COORD_W = 8,
   parameter int COLOR_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cpu_req,
   input  logic [COORD_W-1:0] cpu_x,
   input  logic [COORD_W-1:0] cpu_y,
   input  logic [COLOR_W-1:0] cpu_r,
   input  logic [COLOR_W-1:0] cpu_g,
   input  logic [COLOR_W-1:0] cpu_b,
   output logic               cpu_gnt,
   input  logic               clr_start,
   input  logic [COLOR_W-1:0] clr_r,
   input  logic [COLOR_W-1:0] clr_g,
   input  logic [COLOR_W-1:0] clr_b,
   input  logic               display,
   input  logic               vblank,
   output logic [COORD_W-1:0] fb_x,
   output logic [COORD_W-1:0] fb_y,
   output logic [COLOR_W-1:0] fb_r,
   output logic [COLOR_W-1:0] fb_g,
   output logic [COLOR_W-1:0] fb_b,
   output logic               fb_we,
   output logic               swap,
   output logic               busy
);

   typedef enum logic [1:0] {IDLE, CLEAR, SWAP_WAIT} state_t;

   state_t               state;
   logic                 swap_pending;
   logic                 vblank_q;
   logic [2*COORD_W-1:0] clr_addr;
   logic [2*COORD_W-1:0] clr_next;

   // The registered write address doubles as the clear counter: {y,x}, x in the low bits.
   assign clr_addr = {fb_y, fb_x};
   assign clr_next = clr_addr + (2*COORD_W)'(1);

   assign cpu_gnt = (state == IDLE) & cpu_req & ~clr_start & ~swap_pending;
   assign busy    = (state != IDLE) | swap_pending;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         swap_pending <= 1'b0;
         vblank_q     <= 1'b0;
         fb_x         <= '0;
         fb_y         <= '0;
         fb_r         <= '0;
         fb_g         <= '0;
         fb_b         <= '0;
         fb_we        <= 1'b0;
         swap         <= 1'b0;
      end else begin
         vblank_q <= vblank;
         fb_we    <= 1'b0;
         swap     <= 1'b0;
         if (display) begin
            swap_pending <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (clr_start) begin
                  state <= CLEAR;
                  fb_we <= 1'b1;
                  fb_x  <= '0;
                  fb_y  <= '0;
                  fb_r  <= clr_r;
                  fb_g  <= clr_g;
                  fb_b  <= clr_b;
               end else if (cpu_gnt) begin
                  fb_we <= 1'b1;
                  fb_x  <= cpu_x;
                  fb_y  <= cpu_y;
                  fb_r  <= cpu_r;
                  fb_g  <= cpu_g;
                  fb_b  <= cpu_b;
               end else if (swap_pending) begin
                  state <= SWAP_WAIT;
               end
            end
            CLEAR: begin
               // Colour outputs keep the fill colour; only the address advances.
               if (clr_addr == '1) begin
                  state <= IDLE;
               end else begin
                  fb_we        <= 1'b1;
                  {fb_y, fb_x} <= clr_next;
               end
            end
            SWAP_WAIT: begin
               if (vblank & ~vblank_q) begin
                  swap         <= 1'b1;
                  swap_pending <= 1'b0;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
